// File: rtl/sort_sequencer_pkg.sv
// Shared definitions for the sort sequencer: slot count, digit modulus and
// the sequencer FSM state encoding.
package sort_sequencer_pkg;

   localparam int unsigned N_SLOTS   = 4;
   localparam logic [3:0]  DIGIT_MOD = 4'd10;

   typedef enum logic [2:0] {
      IDLE,
      SORT_CMP,
      SORT_SWAP,
      PASS_END,
      DONE
   } state_t;

endpackage

// File: rtl/sort_sequencer_step_timer.sv
// Step pacing timer: emits a one-cycle step pulse every STEP_DIV enabled
// cycles. The count holds while en is low and restarts from zero on clr.
//   clk  : system clock
//   rst  : synchronous active-high reset
//   clr  : restart the count from zero
//   en   : count enable (busy and not paused)
//   step : one-cycle pulse on the last count of each period
module step_timer #(
   parameter int unsigned STEP_DIV = 25_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic step
);

   localparam int unsigned CW = $clog2(STEP_DIV);
   localparam logic [CW-1:0] LAST = CW'(STEP_DIV - 1);

   logic [CW-1:0] count;

   assign step = en && (count == LAST);

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         count <= '0;
      end else if (en) begin
         count <= step ? '0 : count + 1'b1;
      end
   end

endmodule

// File: rtl/sort_sequencer.sv
// Visual bubble-sort sequencer for four decimal digit slots. Digits are
// loaded one at a time (raw values reduced mod 10), then sorted ascending
// one compare/swap step per timer period so the progress can be displayed.
//   clk, rst   : clock, synchronous active-high reset
//   load_req   : pulse, capture load_data into the next free slot
//   load_data  : raw 4-bit value
//   start      : pulse, begin a sort run (needs all slots filled)
//   pause      : level, freezes step pacing and all state
//   nums_flat  : slot k on bits [4k+3:4k], slot 0 leftmost
//   cmp_idx    : lower index of the pair being compared
//   swap_flag  : high while a swap step is shown
//   load_cnt   : number of filled slots
//   busy, done : run in progress / last run completed
//   swap_count : swaps made in the current or last run
module sort_sequencer
   import sort_sequencer_pkg::*;
#(
   parameter int unsigned STEP_DIV = 25_000_000,
   parameter int unsigned N        = N_SLOTS
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           load_req,
   input  logic [3:0]     load_data,
   input  logic           start,
   input  logic           pause,
   output logic [4*N-1:0] nums_flat,
   output logic [1:0]     cmp_idx,
   output logic           swap_flag,
   output logic [2:0]     load_cnt,
   output logic           busy,
   output logic           done,
   output logic [2:0]     swap_count
);

   state_t     state, state_n;
   logic [3:0] slots   [N];
   logic [3:0] slots_n [N];
   logic [2:0] load_cnt_n;
   logic [1:0] j, j_n, j_p1;
   logic [1:0] pass, pass_n;
   logic       pass_swapped, pass_swapped_n;
   logic [2:0] swap_count_n;
   logic [3:0] digit;
   logic       step, timer_clr, timer_en;
   logic       load_ok, start_ok, last_j;

   assign digit = (load_data >= DIGIT_MOD) ? load_data - DIGIT_MOD : load_data;

   assign busy      = state inside {SORT_CMP, SORT_SWAP, PASS_END};
   assign done      = (state == DONE);
   assign swap_flag = (state == SORT_SWAP);
   assign cmp_idx   = j;
   assign timer_en  = busy && !pause;

   assign j_p1   = j + 2'd1;
   assign last_j = (j >= (2'd2 - pass));

   // A full buffer only accepts a load in DONE, where it begins a fresh set.
   assign load_ok  = load_req && ((load_cnt != 3'd4) ? (state == IDLE || state == DONE)
                                                      : (state == DONE));
   assign start_ok = start && !load_req && load_cnt == 3'd4
                     && (state == IDLE || state == DONE);

   step_timer #(
      .STEP_DIV(STEP_DIV)
   ) u_step_timer (
      .clk (clk),
      .rst (rst),
      .clr (timer_clr),
      .en  (timer_en),
      .step(step)
   );

   always_comb begin
      nums_flat = '0;
      for (int unsigned k = 0; k < N; k++) begin
         nums_flat[4*k +: 4] = slots[k];
      end
   end

   always_comb begin
      state_n        = state;
      slots_n        = slots;
      load_cnt_n     = load_cnt;
      j_n            = j;
      pass_n         = pass;
      pass_swapped_n = pass_swapped;
      swap_count_n   = swap_count;
      timer_clr      = 1'b0;
      case (state)
         IDLE, DONE: begin
            if (load_ok) begin
               if (load_cnt == 3'd4) begin
                  for (int unsigned k = 0; k < N; k++) begin
                     slots_n[k] = '0;
                  end
                  slots_n[0] = digit;
                  load_cnt_n = 3'd1;
                  state_n    = IDLE;
               end else begin
                  slots_n[load_cnt[1:0]] = digit;
                  load_cnt_n = load_cnt + 3'd1;
               end
            end else if (start_ok) begin
               state_n        = SORT_CMP;
               j_n            = '0;
               pass_n         = '0;
               pass_swapped_n = 1'b0;
               swap_count_n   = '0;
               timer_clr      = 1'b1;
            end
         end
         SORT_CMP: begin
            if (step) begin
               // The exchange is committed on entry to SORT_SWAP so the
               // swapped values are on display for the whole swap step.
               if (slots[j] > slots[j_p1]) begin
                  slots_n[j]     = slots[j_p1];
                  slots_n[j_p1]  = slots[j];
                  swap_count_n   = swap_count + 3'd1;
                  pass_swapped_n = 1'b1;
                  state_n        = SORT_SWAP;
               end else if (last_j) begin
                  state_n = PASS_END;
               end else begin
                  j_n = j_p1;
               end
            end
         end
         SORT_SWAP: begin
            if (step) begin
               if (last_j) begin
                  state_n = PASS_END;
               end else begin
                  j_n     = j_p1;
                  state_n = SORT_CMP;
               end
            end
         end
         PASS_END: begin
            if (!pause) begin
               if (!pass_swapped || pass == 2'd2) begin
                  state_n = DONE;
               end else begin
                  pass_n         = pass + 2'd1;
                  j_n            = '0;
                  pass_swapped_n = 1'b0;
                  state_n        = SORT_CMP;
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         for (int unsigned k = 0; k < N; k++) begin
            slots[k] <= '0;
         end
         load_cnt     <= '0;
         j            <= '0;
         pass         <= '0;
         pass_swapped <= 1'b0;
         swap_count   <= '0;
      end else begin
         state        <= state_n;
         slots        <= slots_n;
         load_cnt     <= load_cnt_n;
         j            <= j_n;
         pass         <= pass_n;
         pass_swapped <= pass_swapped_n;
         swap_count   <= swap_count_n;
      end
   end

endmodule

// File: tb/tb_sort_sequencer.sv
// Self-checking bench for sort_sequencer with a fast step period.
module tb_sort_sequencer;

   localparam int unsigned STEP_DIV = 4;

   logic        clk = 1'b0;
   logic        rst, load_req, start, pause;
   logic [3:0]  load_data;
   logic [15:0] nums_flat;
   logic [1:0]  cmp_idx;
   logic        swap_flag, busy, done;
   logic [2:0]  load_cnt, swap_count;

   typedef struct {
      logic [15:0] flat;
      int          swaps;
   } exp_t;

   exp_t       sb[$];
   logic [3:0] m_slots [4];
   int         m_cnt;
   bit         m_done;
   int         vectors = 0;
   int         errors  = 0;

   sort_sequencer #(
      .STEP_DIV(STEP_DIV),
      .N       (4)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .load_req  (load_req),
      .load_data (load_data),
      .start     (start),
      .pause     (pause),
      .nums_flat (nums_flat),
      .cmp_idx   (cmp_idx),
      .swap_flag (swap_flag),
      .load_cnt  (load_cnt),
      .busy      (busy),
      .done      (done),
      .swap_count(swap_count)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] model_flat();
      return {m_slots[3], m_slots[2], m_slots[1], m_slots[0]};
   endfunction

   function automatic exp_t model_sort();
      logic [3:0] a [4];
      logic [3:0] t;
      exp_t r;
      a = m_slots;
      r.swaps = 0;
      for (int p = 0; p < 3; p++) begin
         for (int k = 0; k < 3 - p; k++) begin
            if (a[k] > a[k+1]) begin
               t = a[k]; a[k] = a[k+1]; a[k+1] = t;
               r.swaps++;
            end
         end
      end
      r.flat = {a[3], a[2], a[1], a[0]};
      return r;
   endfunction

   task automatic model_clear();
      for (int k = 0; k < 4; k++) m_slots[k] = 4'd0;
      m_cnt  = 0;
      m_done = 0;
      sb.delete();
   endtask

   task automatic model_finish(input exp_t e);
      for (int k = 0; k < 4; k++) m_slots[k] = e.flat[4*k +: 4];
      m_done = 1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      model_clear();
   endtask

   task automatic do_load(input logic [3:0] v);
      if (m_cnt == 4 && m_done) begin
         for (int k = 0; k < 4; k++) m_slots[k] = 4'd0;
         m_slots[0] = 4'(v % 10);
         m_cnt  = 1;
         m_done = 0;
      end else if (m_cnt < 4) begin
         m_slots[m_cnt] = 4'(v % 10);
         m_cnt++;
      end
      @(negedge clk);
      load_req  = 1'b1;
      load_data = v;
      @(negedge clk);
      load_req  = 1'b0;
   endtask

   task automatic do_start();
      if (m_cnt == 4) begin
         sb.push_back(model_sort());
         m_done = 0;
      end
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(output int cycles, output bit saw_swap);
      cycles   = -1;
      saw_swap = 0;
      for (int i = 1; i <= 400; i++) begin
         @(negedge clk);
         if (swap_flag) saw_swap = 1;
         if (done) begin
            cycles = i;
            return;
         end
      end
      vectors++;
      errors++;
      $display("FAIL wait_done: done=%b after 400 cycles, required 1", done);
   endtask

   task automatic test_reset();
      do_reset();
      vectors++;
      if ({nums_flat, cmp_idx, swap_flag, load_cnt, busy, done, swap_count} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: nums=%h cmp=%0d swf=%b cnt=%0d busy=%b done=%b sc=%0d, required all 0",
                  nums_flat, cmp_idx, swap_flag, load_cnt, busy, done, swap_count);
      end
   endtask

   task automatic test_sort_basic();
      exp_t e;
      int   cyc;
      bit   sw;
      do_load(4'd7); do_load(4'd3); do_load(4'd9); do_load(4'd1);
      vectors++;
      if (nums_flat !== model_flat() || load_cnt !== 3'd4) begin
         errors++;
         $display("FAIL basic_loaded: nums=%h cnt=%0d, required nums=%h cnt=4", nums_flat, load_cnt, model_flat());
      end
      do_start();
      vectors++;
      if (busy !== 1'b1 || done !== 1'b0 || cmp_idx !== 2'd0 || swap_count !== 3'd0) begin
         errors++;
         $display("FAIL basic_started: busy=%b done=%b cmp=%0d sc=%0d, required 1 0 0 0", busy, done, cmp_idx, swap_count);
      end
      wait_done(cyc, sw);
      vectors++;
      if (sb.size() != 1) begin
         errors++;
         $display("FAIL basic_scoreboard: %0d entries, required 1", sb.size());
      end else begin
         e = sb.pop_front();
         model_finish(e);
         vectors++;
         if (nums_flat !== e.flat || nums_flat !== 16'h9731) begin
            errors++;
            $display("FAIL basic_sorted: nums=%h, required %h", nums_flat, e.flat);
         end
         vectors++;
         if (swap_count !== 3'(e.swaps) || swap_count !== 3'd4) begin
            errors++;
            $display("FAIL basic_swaps: sc=%0d, required %0d", swap_count, e.swaps);
         end
         vectors++;
         if (done !== 1'b1 || busy !== 1'b0 || swap_flag !== 1'b0) begin
            errors++;
            $display("FAIL basic_done: done=%b busy=%b swf=%b, required 1 0 0", done, busy, swap_flag);
         end
      end
   endtask

   task automatic test_sorted_input();
      exp_t e;
      int   cyc;
      bit   sw;
      do_load(4'd1);
      vectors++;
      if (nums_flat !== 16'h0001 || load_cnt !== 3'd1 || done !== 1'b0) begin
         errors++;
         $display("FAIL reload_from_done: nums=%h cnt=%0d done=%b, required 0001 1 0", nums_flat, load_cnt, done);
      end
      do_load(4'd2); do_load(4'd3); do_load(4'd4);
      do_start();
      wait_done(cyc, sw);
      vectors++;
      if (cyc !== int'(3 * STEP_DIV + 1)) begin
         errors++;
         $display("FAIL sorted_latency: %0d cycles, required %0d", cyc, 3 * STEP_DIV + 1);
      end
      vectors++;
      if (sw !== 1'b0 || swap_count !== 3'd0) begin
         errors++;
         $display("FAIL sorted_noswap: swap_seen=%b sc=%0d, required 0 0", sw, swap_count);
      end
      if (sb.size() == 1) begin
         e = sb.pop_front();
         model_finish(e);
         vectors++;
         if (nums_flat !== e.flat) begin
            errors++;
            $display("FAIL sorted_result: nums=%h, required %h", nums_flat, e.flat);
         end
      end
   endtask

   task automatic test_rerun();
      exp_t e;
      int   cyc;
      bit   sw;
      do_start();
      vectors++;
      if (busy !== 1'b1 || done !== 1'b0) begin
         errors++;
         $display("FAIL rerun_start: busy=%b done=%b, required 1 0", busy, done);
      end
      wait_done(cyc, sw);
      if (sb.size() == 1) begin
         e = sb.pop_front();
         model_finish(e);
         vectors++;
         if (nums_flat !== e.flat || swap_count !== 3'(e.swaps)) begin
            errors++;
            $display("FAIL rerun_result: nums=%h sc=%0d, required %h %0d", nums_flat, swap_count, e.flat, e.swaps);
         end
      end
   endtask

   task automatic test_pause();
      exp_t        e;
      int          cyc;
      bit          sw;
      bit          moved;
      logic [26:0] snap;
      do_load(4'd4); do_load(4'd3); do_load(4'd2); do_load(4'd1);
      do_start();
      repeat (10) @(negedge clk);
      pause = 1'b1;
      snap  = {nums_flat, cmp_idx, swap_flag, load_cnt, busy, done, swap_count};
      moved = 0;
      repeat (20) begin
         @(negedge clk);
         if ({nums_flat, cmp_idx, swap_flag, load_cnt, busy, done, swap_count} !== snap) moved = 1;
      end
      vectors++;
      if (moved !== 1'b0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL pause_frozen: changed=%b busy=%b, required 0 1", moved, busy);
      end
      pause = 1'b0;
      wait_done(cyc, sw);
      if (sb.size() == 1) begin
         e = sb.pop_front();
         model_finish(e);
         vectors++;
         if (nums_flat !== e.flat || nums_flat !== 16'h4321) begin
            errors++;
            $display("FAIL pause_sorted: nums=%h, required %h", nums_flat, e.flat);
         end
         vectors++;
         if (swap_count !== 3'(e.swaps) || swap_count !== 3'd6) begin
            errors++;
            $display("FAIL pause_swaps: sc=%0d, required %0d", swap_count, e.swaps);
         end
      end
   endtask

   task automatic test_load_mod();
      do_reset();
      do_load(4'd12); do_load(4'd15); do_load(4'd9); do_load(4'd10);
      vectors++;
      if (nums_flat !== model_flat() || nums_flat !== 16'h0952) begin
         errors++;
         $display("FAIL load_mod: nums=%h, required %h", nums_flat, model_flat());
      end
      do_load(4'd7);
      vectors++;
      if (load_cnt !== 3'd4 || nums_flat !== model_flat()) begin
         errors++;
         $display("FAIL load_fifth: cnt=%0d nums=%h, required 4 %h", load_cnt, nums_flat, model_flat());
      end
   endtask

   task automatic test_start_ignored();
      exp_t e;
      int   cyc;
      bit   sw;
      do_reset();
      do_load(4'd5); do_load(4'd6);
      do_start();
      vectors++;
      if (busy !== 1'b0 || load_cnt !== 3'd2 || sb.size() != 0) begin
         errors++;
         $display("FAIL start_partial: busy=%b cnt=%0d, required 0 2", busy, load_cnt);
      end
      m_slots[2] = 4'd8;
      m_cnt      = 3;
      @(negedge clk);
      load_req  = 1'b1;
      start     = 1'b1;
      load_data = 4'd8;
      @(negedge clk);
      load_req = 1'b0;
      start    = 1'b0;
      vectors++;
      if (busy !== 1'b0 || load_cnt !== 3'd3 || nums_flat !== model_flat()) begin
         errors++;
         $display("FAIL start_with_load: busy=%b cnt=%0d nums=%h, required 0 3 %h", busy, load_cnt, nums_flat, model_flat());
      end
      do_load(4'd0);
      do_start();
      wait_done(cyc, sw);
      if (sb.size() == 1) begin
         e = sb.pop_front();
         model_finish(e);
         vectors++;
         if (nums_flat !== e.flat || swap_count !== 3'(e.swaps)) begin
            errors++;
            $display("FAIL partial_then_sort: nums=%h sc=%0d, required %h %0d", nums_flat, swap_count, e.flat, e.swaps);
         end
      end
   endtask

   task automatic test_reset_mid();
      bit found;
      do_load(4'd4); do_load(4'd3); do_load(4'd2); do_load(4'd1);
      do_start();
      found = 0;
      for (int i = 0; i < 100 && !found; i++) begin
         @(negedge clk);
         if (swap_flag) found = 1;
      end
      vectors++;
      if (!found) begin
         errors++;
         $display("FAIL reach_swap: swap_flag=%b within 100 cycles, required 1", swap_flag);
      end
      rst = 1'b1;
      @(negedge clk);
      vectors++;
      if ({nums_flat, cmp_idx, swap_flag, load_cnt, busy, done, swap_count} !== '0) begin
         errors++;
         $display("FAIL reset_mid_sort: nums=%h cmp=%0d swf=%b cnt=%0d busy=%b done=%b sc=%0d, required all 0",
                  nums_flat, cmp_idx, swap_flag, load_cnt, busy, done, swap_count);
      end
      rst = 1'b0;
      model_clear();
   endtask

   initial begin
      rst       = 1'b1;
      load_req  = 1'b0;
      load_data = 4'd0;
      start     = 1'b0;
      pause     = 1'b0;
      model_clear();
      test_reset();
      test_sort_basic();
      test_sorted_input();
      test_rerun();
      test_pause();
      test_load_mod();
      test_start_ignored();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
